// File: rtl/arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
//   resp_owner_e         : which requester owns the mem_rdata returning next cycle
//   ARB_STARVE_LIMIT_DEF : default number of consecutive LSU-over-fetch wins
//                          before fetch is forced (only with ARB_STARVE_GUARD_EN)
package arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_LSU  = 2'd2
    } resp_owner_e;

    localparam int unsigned ARB_STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arb_starve.sv
// Starvation guard for mem_port_arbiter (used only when ARB_STARVE_GUARD_EN is defined).
// Counts consecutive cycles in which the LSU was granted while fetch was waiting and raises
// force_fetch once that count reaches STARVE_LIMIT (must be >= 1).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   if_req       : fetch is requesting this cycle
//   if_gnt       : fetch granted this cycle
//   lsu_gnt      : LSU granted this cycle
//   force_fetch  : fetch must win the next contended cycle
module mem_arb_starve
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic lsu_gnt,
    output logic force_fetch
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt || !if_req) begin
            cnt_d = '0;
        end else if (lsu_gnt && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and the load/store unit (LSU).
// LSU has priority; grants are combinational (zero latency), read data returns one cycle
// after the grant and is routed to its owner by a small response FSM.
// Optional macro ARB_STARVE_GUARD_EN adds a guard that forces a fetch grant after
// STARVE_LIMIT consecutive LSU wins over a waiting fetch.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata     : fetch grant and read response
//   lsu_req/we/be/addr/wdata      : LSU request (held until lsu_gnt)
//   lsu_gnt/lsu_rvalid/lsu_rdata  : LSU grant and load response
//   mem_en/we/be/addr/wdata       : RAM port, all zero when idle
//   mem_rdata                     : RAM read data, one cycle after a read access
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [3:0]    lsu_be,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_gnt,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    resp_owner_e state_q, state_d;
    logic        force_fetch;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_gnt     (if_gnt),
        .lsu_gnt    (lsu_gnt),
        .force_fetch(force_fetch)
    );
`else
    // Strict LSU priority; the limit has no effect without the guard.
    assign force_fetch = 1'b0 & (STARVE_LIMIT == 0);
`endif

    // Grants: reset suppresses both so nothing reaches the RAM during reset.
    always_comb begin
        lsu_gnt = !rst && lsu_req && !(force_fetch && if_req);
        if_gnt  = !rst && if_req && !lsu_gnt;
    end

    // RAM port mux.
    always_comb begin
        mem_en    = if_gnt | lsu_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (lsu_gnt) begin
            mem_we    = lsu_we;
            mem_be    = lsu_be;
            mem_addr  = lsu_addr;
            mem_wdata = lsu_wdata;
        end else if (if_gnt) begin
            mem_be    = 4'b1111;
            mem_addr  = if_addr;
        end
    end

    // Response FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESP_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response FSM: next state. Stores return nothing, so they leave no owner.
    always_comb begin
        state_d = RESP_NONE;
        if (if_gnt) begin
            state_d = RESP_IF;
        end else if (lsu_gnt && !lsu_we) begin
            state_d = RESP_LSU;
        end
    end

    // Response FSM: outputs. A read granted just before reset is dropped in the reset cycle.
    always_comb begin
        if_rvalid  = !rst && (state_q == RESP_IF);
        lsu_rvalid = !rst && (state_q == RESP_LSU);
        if_rdata   = if_rvalid ? mem_rdata : '0;
        lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    end

endmodule
